// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB transaction master.
// Holds the request/response packet field offsets, the response status
// codes and the FSM state encoding used by apb_txn_master.
package apb_pkg;

    // Packet layout (48-bit):
    //   request : [47] write, [46:40] slv_id, [39:32] addr, [31:0] wdata
    //   response: [47] write, [46:40] slv_id, [39:38] status, [37:32] zero,
    //             [31:0] rdata
    localparam int PKT_WRITE_BIT  = 47;
    localparam int PKT_SLV_LSB    = 40;
    localparam int PKT_SLV_W      = 7;
    localparam int PKT_ADDR_LSB   = 32;
    localparam int PKT_STATUS_LSB = 38;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_SLVERR  = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0] STATUS_BADID   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_req_fifo.sv
// apb_req_fifo: single-clock synchronous FIFO with registered read data
// (show-ahead off: pop_data is valid the cycle after pop).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write strobe and data (ignored when full)
//   pop, pop_data   read strobe (ignored when empty) and registered data
//   full, empty     occupancy flags
//   count           current occupancy, 0..DEPTH
module apb_req_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr     <= rptr + 1'b1;
                pop_data <= mem[rptr];
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/apb_txn_master.sv
// apb_txn_master: pulls request packets from an upstream FIFO, runs each
// as one APB transfer on the addressed slave and pushes a response packet.
// Ports:
//   apb_clk, apb_rst_n     clock, asynchronous active-low reset
//   pp_wr_fifo_*           upstream request FIFO (empty, pop strobe, data
//                          valid the cycle after the strobe)
//   pp_rd_prog_fifo_full   downstream backpressure
//   pp_rd_fifo_en/_data    downstream response push strobe and packet
//   apb_*                  APB master signals; prdata/pready/pslverr are
//                          per-slave vectors, prdata flattened
//   fsm_state              current FSM state (debug visibility)
//
// Handshakes: upstream, a pop is issued only while pp_wr_fifo_empty=0 and
// the internal buffer has room for it plus any pop whose data is still in
// flight; downstream, a response is pushed (pp_rd_fifo_en=1 for one cycle)
// only for a transaction started while pp_rd_prog_fifo_full was 0; on APB
// a transfer completes in ACCESS on the first cycle pready[slv_id]=1.
module apb_txn_master
    import apb_pkg::*;
#(
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int NUM_SLAVES       = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                             apb_clk,
    input  logic                             apb_rst_n,
    input  logic                             pp_wr_fifo_empty,
    input  logic [RAH_PACKET_WIDTH-1:0]      pp_wr_fifo_read_data,
    output logic                             pp_wr_fifo_read_en,
    input  logic                             pp_rd_prog_fifo_full,
    output logic                             pp_rd_fifo_en,
    output logic [RAH_PACKET_WIDTH-1:0]      pp_rd_fifo_data,
    output logic [NUM_SLAVES-1:0]            apb_psel,
    output logic                             apb_penable,
    output logic                             apb_pwrite,
    output logic [ADDR_WIDTH-1:0]            apb_paddr,
    output logic [DATA_WIDTH-1:0]            apb_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] apb_prdata,
    input  logic [NUM_SLAVES-1:0]            apb_pready,
    input  logic [NUM_SLAVES-1:0]            apb_pslverr,
    output logic [1:0]                       fsm_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PKT_SLV_W-1:0] NUM_SLAVES_C = PKT_SLV_W'(NUM_SLAVES);

    state_t state, state_next;

    logic                        ingest_en;
    logic                        rd_pending;
    logic [RAH_PACKET_WIDTH-1:0] fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_pop;
    logic                        stage_valid;
    logic                        consume;
    logic                        head_ok;

    logic                        pkt_write;
    logic [PKT_SLV_W-1:0]        pkt_slv;
    logic [ADDR_WIDTH-1:0]       pkt_addr;
    logic [DATA_WIDTH-1:0]       pkt_wdata;
    logic [1:0]                  status_q;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic [TW-1:0]               wait_cnt;

    logic [NUM_SLAVES-1:0]       sel_onehot;
    logic [DATA_WIDTH-1:0]       sel_rdata;
    logic                        sel_ready;
    logic                        sel_err;

    // ingest_en keeps the pop strobe low while in reset and for the first
    // edge after it, so no pop is issued from a reset state.
    assign pp_wr_fifo_read_en = ingest_en && !pp_wr_fifo_empty && !fifo_full &&
                                ((fifo_count + CW'(rd_pending)) < DEPTH_C);

    apb_req_fifo #(
        .WIDTH (RAH_PACKET_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (apb_clk),
        .rst_n     (apb_rst_n),
        .push      (rd_pending),
        .push_data (pp_wr_fifo_read_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The buffer's read data is registered, so one entry is prefetched into
    // its output register (stage_valid) ahead of IDLE. Refilling in the same
    // cycle the staged entry is consumed keeps back-to-back transfers at
    // 4 cycles. Prefetch is held off under backpressure so the buffer alone
    // absorbs a stalled stream.
    assign fifo_pop = !fifo_empty && !pp_rd_prog_fifo_full && (!stage_valid || consume);
    assign head_ok  = (fifo_dout[PKT_SLV_LSB +: PKT_SLV_W] < NUM_SLAVES_C);

    always_comb begin
        sel_onehot = '0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (pkt_slv == PKT_SLV_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_rdata     = apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_ready = |(apb_pready & sel_onehot);
    assign sel_err   = |(apb_pslverr & sel_onehot);
    assign fsm_state = state;

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        consume         = 1'b0;
        apb_psel        = '0;
        apb_penable     = 1'b0;
        apb_pwrite      = 1'b0;
        apb_paddr       = '0;
        apb_pwdata      = '0;
        pp_rd_fifo_en   = 1'b0;
        pp_rd_fifo_data = '0;
        case (state)
            ST_IDLE: begin
                if (stage_valid && !pp_rd_prog_fifo_full) begin
                    consume    = 1'b1;
                    state_next = head_ok ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                apb_psel   = sel_onehot;
                apb_pwrite = pkt_write;
                apb_paddr  = pkt_addr;
                apb_pwdata = pkt_wdata;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                apb_psel    = sel_onehot;
                apb_penable = 1'b1;
                apb_pwrite  = pkt_write;
                apb_paddr   = pkt_addr;
                apb_pwdata  = pkt_wdata;
                if (sel_ready || (wait_cnt == TIMEOUT_LAST)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                pp_rd_fifo_en   = 1'b1;
                pp_rd_fifo_data = RAH_PACKET_WIDTH'({pkt_write, pkt_slv, status_q,
                                                     6'b0, rdata_q});
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            ingest_en   <= 1'b0;
            rd_pending  <= 1'b0;
            stage_valid <= 1'b0;
            pkt_write   <= 1'b0;
            pkt_slv     <= '0;
            pkt_addr    <= '0;
            pkt_wdata   <= '0;
            status_q    <= STATUS_OK;
            rdata_q     <= '0;
            wait_cnt    <= '0;
        end else begin
            ingest_en   <= 1'b1;
            rd_pending  <= pp_wr_fifo_read_en;
            stage_valid <= fifo_pop || (stage_valid && !consume);
            if (consume) begin
                pkt_write <= fifo_dout[PKT_WRITE_BIT];
                pkt_slv   <= fifo_dout[PKT_SLV_LSB +: PKT_SLV_W];
                pkt_addr  <= fifo_dout[PKT_ADDR_LSB +: ADDR_WIDTH];
                pkt_wdata <= fifo_dout[DATA_WIDTH-1:0];
                status_q  <= head_ok ? STATUS_OK : STATUS_BADID;
                rdata_q   <= '0;
            end
            if (state == ST_ACCESS) begin
                if (sel_ready) begin
                    status_q <= sel_err ? STATUS_SLVERR : STATUS_OK;
                    rdata_q  <= pkt_write ? '0 : sel_rdata;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    status_q <= STATUS_TIMEOUT;
                end
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_txn_master.sv
// tb_apb_txn_master: directed, table-driven bench for apb_txn_master.
// Models an upstream request FIFO, an APB slave per select line and a
// response scoreboard with an expected queue.
module tb_apb_txn_master;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PW = 48;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             up_empty = 1'b1;
    logic [PW-1:0]    up_data = '0;
    logic             rd_en;
    logic             prog_full = 1'b0;
    logic             resp_en;
    logic [PW-1:0]    resp_data;
    logic [NS-1:0]    psel;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [NS*DW-1:0] prdata = '0;
    logic [NS-1:0]    pready = '0;
    logic [NS-1:0]    pslverr = '0;
    logic [1:0]       fsm_state;

    apb_txn_master dut (
        .apb_clk              (clk),
        .apb_rst_n            (rst_n),
        .pp_wr_fifo_empty     (up_empty),
        .pp_wr_fifo_read_data (up_data),
        .pp_wr_fifo_read_en   (rd_en),
        .pp_rd_prog_fifo_full (prog_full),
        .pp_rd_fifo_en        (resp_en),
        .pp_rd_fifo_data      (resp_data),
        .apb_psel             (psel),
        .apb_penable          (penable),
        .apb_pwrite           (pwrite),
        .apb_paddr            (paddr),
        .apb_pwdata           (pwdata),
        .apb_prdata           (prdata),
        .apb_pready           (pready),
        .apb_pslverr          (pslverr),
        .fsm_state            (fsm_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- upstream FIFO model ----------------
    logic [PW-1:0] up_q[$];
    initial begin
        logic take;
        forever begin
            @(negedge clk);
            take = rd_en;
            @(posedge clk);
            #1;
            if (take && up_q.size() > 0) up_data = up_q.pop_front();
            up_empty = (up_q.size() == 0);
        end
    end

    // ---------------- APB slave model ----------------
    int          sl_delay = 0;
    logic        sl_never = 1'b0;
    logic        sl_err = 1'b0;
    logic        sl_addr_mode = 1'b0;
    logic [31:0] sl_rdata = '0;
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            pready  = '0;
            pslverr = '0;
            prdata  = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
            if (penable) begin
                acc_cnt++;
                for (int i = 0; i < NS; i++) begin
                    if (psel[i]) begin
                        prdata[i*DW +: DW] = sl_addr_mode ? {24'h5A5A5A, paddr} : sl_rdata;
                        if (!sl_never && acc_cnt > sl_delay) begin
                            pready[i]  = 1'b1;
                            pslverr[i] = sl_err;
                        end
                    end
                end
            end else begin
                acc_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int            cycle = 0;
    int            resp_cnt = 0;
    int            resp_cyc[$];
    int            psel_cyc = 0;
    int            pen_cyc = 0;
    logic [NS-1:0] psel_or = '0;
    int            onehot_err = 0;
    int            stab_err = 0;
    logic [NS-1:0] setup_psel = '0;
    logic [AW-1:0] setup_addr = '0;
    logic          setup_write = 1'b0;
    logic [DW-1:0] setup_wdata = '0;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        forever begin
            @(negedge clk);
            if ($countones(psel) > 1) onehot_err++;
            if (psel != '0) begin
                psel_cyc++;
                psel_or = psel_or | psel;
            end
            if (psel != '0 && !penable) begin
                setup_psel  = psel;
                setup_addr  = paddr;
                setup_write = pwrite;
                setup_wdata = pwdata;
            end
            if (penable) begin
                pen_cyc++;
                if (psel != setup_psel || paddr != setup_addr ||
                    pwrite != setup_write || pwdata != setup_wdata) stab_err++;
            end
            if (resp_en) begin
                resp_cnt++;
                resp_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got 0x%0h expected none", resp_data);
                end else begin
                    check("resp_packet", 64'(resp_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic clear_mon();
        psel_cyc = 0;
        pen_cyc  = 0;
        psel_or  = '0;
        resp_cyc.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [PW-1:0] req;
        int            delay;
        logic          never;
        logic          err;
        logic [31:0]   rdata;
        logic [PW-1:0] exp_resp;
        int            exp_psel_cyc;
        int            exp_pen_cyc;
        logic [NS-1:0] exp_psel;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vector(input vec_t vv, input int idx);
        int base;
        int t;
        clear_mon();
        sl_delay     = vv.delay;
        sl_never     = vv.never;
        sl_err       = vv.err;
        sl_rdata     = vv.rdata;
        sl_addr_mode = 1'b0;
        base = resp_cnt;
        exp_q.push_back(vv.exp_resp);
        up_q.push_back(vv.req);
        t = 0;
        while (resp_cnt == base && t < 600) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("vector %0d", idx);
        check("resp_count", 64'(resp_cnt - base), 64'd1);
        check("psel_cycles", 64'(psel_cyc), 64'(vv.exp_psel_cyc));
        check("penable_cycles", 64'(pen_cyc), 64'(vv.exp_pen_cyc));
        check("psel_value", 64'(psel_or), 64'(vv.exp_psel));
        if (vv.exp_psel_cyc != 0) begin
            check("setup_paddr", 64'(setup_addr), 64'(vv.req[39:32]));
            check("setup_pwrite", 64'(setup_write), 64'(vv.req[47]));
            check("setup_pwdata", 64'(setup_wdata), 64'(vv.req[31:0]));
        end
    endtask

    // 20 requests under backpressure, then release and drain in order.
    task automatic run_burst();
        int base;
        int t;
        int bad;
        logic [6:0]    s;
        logic [7:0]    a;
        logic          w;
        logic [31:0]   d;
        clear_mon();
        sl_delay = 0; sl_never = 1'b0; sl_err = 1'b0; sl_addr_mode = 1'b1;
        prog_full = 1'b1;
        base = resp_cnt;
        for (int i = 0; i < 20; i++) begin
            s = 7'(i % 4);
            a = 8'(i * 3 + 1);
            w = (i % 2 == 1);
            d = 32'hB000_0000 | 32'(i);
            up_q.push_back({w, s, a, d});
            exp_q.push_back(w ? {w, s, 2'b00, 6'b0, 32'h0}
                              : {w, s, 2'b00, 6'b0, 24'h5A5A5A, a});
        end
        repeat (50) @(posedge clk);
        #1;
        check("stall_upstream_left", 64'(up_q.size()), 64'd4);
        check("stall_read_en", 64'(rd_en), 64'd0);
        check("stall_no_resp", 64'(resp_cnt - base), 64'd0);
        check("stall_no_psel", 64'(psel_cyc), 64'd0);
        prog_full = 1'b0;
        t = 0;
        while (resp_cnt - base < 20 && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("burst_resp_count", 64'(resp_cnt - base), 64'd20);
        check("burst_exp_left", 64'(exp_q.size()), 64'd0);
        bad = 0;
        for (int k = 1; k < resp_cyc.size(); k++) begin
            if (resp_cyc[k] - resp_cyc[k-1] != 4) bad++;
        end
        check("burst_spacing_bad", 64'(bad), 64'd0);
        sl_addr_mode = 1'b0;
    endtask

    // Reset asserted mid-ACCESS: outputs drop at once, nothing is emitted.
    task automatic run_reset_abort();
        int t;
        int base;
        clear_mon();
        sl_never = 1'b1;
        sl_err   = 1'b0;
        up_q.push_back({1'b0, 7'd1, 8'h55, 32'h0});
        up_q.push_back({1'b1, 7'd0, 8'h66, 32'h1234_0000});
        up_q.push_back({1'b1, 7'd2, 8'h77, 32'h5678_0000});
        t = 0;
        while (!penable && t < 50) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        check("pre_reset_penable", 64'(penable), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_psel", 64'(psel), 64'd0);
        check("rst_async_penable", 64'(penable), 64'd0);
        check("rst_async_state", 64'(fsm_state), 64'd0);
        up_q.delete();
        sl_never = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = resp_cnt;
        clear_mon();
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_resp", 64'(resp_cnt - base), 64'd0);
        check("post_rst_no_psel", 64'(psel_cyc), 64'd0);
        check("post_rst_state_idle", 64'(fsm_state), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{48'h82_10_DEAD_BEEF, 0, 1'b0, 1'b0, 32'h0,
                    48'h82_00_0000_0000, 2, 1, 4'b0100};
        vecs[1] = '{48'h01_20_0000_0000, 5, 1'b0, 1'b0, 32'h1234_5678,
                    48'h01_00_1234_5678, 7, 6, 4'b0010};
        vecs[2] = '{48'h03_30_0000_0000, 0, 1'b1, 1'b0, 32'hFFFF_FFFF,
                    48'h03_80_0000_0000, 256, 255, 4'b1000};
        vecs[3] = '{48'h85_40_1111_2222, 0, 1'b0, 1'b0, 32'h0,
                    48'h85_C0_0000_0000, 0, 0, 4'b0000};
        vecs[4] = '{48'h00_04_0000_0000, 2, 1'b0, 1'b1, 32'hCAFE_F00D,
                    48'h00_40_CAFE_F00D, 4, 3, 4'b0001};
        vecs[5] = '{48'h83_FF_0000_0001, 1, 1'b0, 1'b0, 32'h0,
                    48'h83_00_0000_0000, 3, 2, 4'b1000};
        vecs[6] = '{48'h04_00_0000_0000, 0, 1'b0, 1'b0, 32'h0,
                    48'h04_C0_0000_0000, 0, 0, 4'b0000};
        vecs[7] = '{48'h7F_00_0000_0000, 0, 1'b0, 1'b0, 32'h0,
                    48'h7F_C0_0000_0000, 0, 0, 4'b0000};
        vecs[8] = '{48'h02_01_0000_0000, 0, 1'b0, 1'b0, 32'h89AB_CDEF,
                    48'h02_00_89AB_CDEF, 2, 1, 4'b0100};
        vecs[9] = '{48'h81_22_5555_AAAA, 0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                    48'h81_40_0000_0000, 2, 1, 4'b0010};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_read_en", 64'(rd_en), 64'd0);
        check("rst_resp_en", 64'(resp_en), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) run_vector(vecs[v], v);
        run_burst();
        run_reset_abort();
        run_vector(vecs[0], 0);

        check("onehot_violations", 64'(onehot_err), 64'd0);
        check("access_stability_violations", 64'(stab_err), 64'd0);
        check("final_exp_left", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
